// File: rtl/led_scan_mux.sv
// Purpose : four-digit time-multiplexed scanner for a common-anode 7-segment display.
// Latency : all outputs registered; a new value takes effect at the next digit-3 -> digit-0 wrap.
// Backpr. : none; LOAD is accepted on every cycle and simply overwrites the shadow copy.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous reset, active-low
//   value     16-bit display value, digit d = value[4d+3:4d], digit 0 rightmost
//   load      capture strobe for value/dp into the shadow registers
//   dp        decimal-point request per digit, active-high
//   digit_en  per-digit enable (0 = digit always dark)
//   lz_en     leading-zero suppression enable
//   nibble    hex code of the digit being scanned (to the 7-segment decoder)
//   dp_n      decimal point, active-low
//   an        digit anodes, active-low, one-hot-low or all-high
//   frame     one-cycle pulse on the first cycle of every digit-0 slot
module led_scan_mux #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp,
  input  logic [3:0]  digit_en,
  input  logic        lz_en,
  output logic [3:0]  nibble,
  output logic        dp_n,
  output logic [3:0]  an,
  output logic        frame
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  // One display image: the four nibbles plus their decimal points.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
  } disp_t;

  disp_t            shadow;
  disp_t            active;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       dig;
  logic             vis_q;

  logic             slot_start;
  logic             slot_last;
  logic             frame_last;
  logic             in_blank;
  logic [3:0]       zero_nib;
  logic [3:0]       suppress;
  logic             vis_live;
  logic             vis_now;
  logic             drive_on;
  logic [3:0]       cur_nib;
  logic             cur_dp;
  logic [3:0]       an_sel;

  // cnt/dig name the slot position that the next clock edge will present on
  // the outputs, so the first edge after reset shows position (cnt=0, dig=0).
  always_comb begin
    slot_start = (cnt == '0);
    slot_last  = (cnt == CNT_LAST);
    frame_last = slot_last && (dig == 2'd3);
    in_blank   = (cnt < BLANK_END);

    for (int i = 0; i < 4; i++) begin
      zero_nib[i] = (active.value[4*i +: 4] == 4'h0);
    end

    // Digit d>0 is a leading zero when it and every digit to its left are zero.
    suppress = {zero_nib[3],
                &zero_nib[3:2],
                &zero_nib[3:1],
                1'b0};

    // Enables are sampled at slot start; the held copy keeps the anode
    // steady for the rest of the slot even if the inputs move.
    vis_live = digit_en[dig] & ~(lz_en & suppress[dig]);
    vis_now  = slot_start ? vis_live : vis_q;
    drive_on = vis_now & ~in_blank;

    cur_nib  = active.value[{dig, 2'b00} +: 4];
    cur_dp   = active.dp[dig];
    an_sel   = ~(4'b0001 << dig);
  end

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      dig <= 2'd0;
    end else if (slot_last) begin
      cnt <= '0;
      dig <= dig + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Double buffer: the active image only changes on the edge that ends the
  // digit-3 slot, so every frame is drawn from a single image. A LOAD on that
  // same edge lands in shadow only and waits for the following wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (load) begin
        shadow <= '{value: value, dp: dp};
      end
      if (frame_last) begin
        active <= shadow;
      end
    end
  end

  // Per-slot visibility hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vis_q <= 1'b0;
    end else if (slot_start) begin
      vis_q <= vis_live;
    end
  end

  // Registered display outputs. nibble is loaded on the first cycle of the
  // slot, while the anodes are still blanked (unless BLANK_CYC is 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an     <= 4'b1111;
      nibble <= 4'h0;
      dp_n   <= 1'b1;
      frame  <= 1'b0;
    end else begin
      an    <= drive_on ? an_sel : 4'b1111;
      dp_n  <= drive_on ? ~cur_dp : 1'b1;
      frame <= slot_start && (dig == 2'd0);
      if (slot_start) begin
        nibble <= cur_nib;
      end
    end
  end

endmodule

// File: tb/tb_led_scan_mux.sv
module tb_led_scan_mux;

  localparam int R = 8;
  localparam int B = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic        lz_en;
  logic [3:0]  nibble;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame;

  led_scan_mux #(.REFRESH_DIV(R), .BLANK_CYC(B)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .load     (load),
    .dp       (dp),
    .digit_en (digit_en),
    .lz_en    (lz_en),
    .nibble   (nibble),
    .dp_n     (dp_n),
    .an       (an),
    .frame    (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] nib;
    logic       dp_n;
    logic       frame;
  } exp_t;

  exp_t       sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [3:0] an_code [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected output for n cycles of the slot of digit d.
  task automatic push_slot(input int d, input logic [3:0] nib, input logic vis,
                           input logic dpa, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.nib   = nib;
      e.an    = (i >= B && vis) ? an_code[d] : 4'b1111;
      e.dp_n  = (i >= B && vis && dpa) ? 1'b0 : 1'b1;
      e.frame = (d == 0 && i == 0);
      sb_q.push_back(e);
    end
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] vis, input logic [3:0] dpa);
    for (int d = 0; d < 4; d++) begin
      push_slot(d, v[4*d +: 4], vis[d], dpa[d], R);
    end
  endtask

  // Advance n clocks, comparing each output cycle against the scoreboard.
  task automatic run(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      assert (sb_q.size() > 0) else begin
        failures++;
        $error("FAIL sb_underflow cycle=%0d observed=empty expected=entry", cyc);
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk($sformatf("an@%0d", cyc), an, e.an);
        chk($sformatf("nibble@%0d", cyc), nibble, e.nib);
        chk($sformatf("dp_n@%0d", cyc), {3'b0, dp_n}, {3'b0, e.dp_n});
        chk($sformatf("frame@%0d", cyc), {3'b0, frame}, {3'b0, e.frame});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    value    = 16'h0000;
    load     = 1'b0;
    dp       = 4'b0000;
    digit_en = 4'b1111;
    lz_en    = 1'b0;

    // Reset held with the clock running.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 4'b1111);
    chk("rst_nibble", nibble, 4'h0);
    chk("rst_dp_n", {3'b0, dp_n}, 4'd1);
    chk("rst_frame", {3'b0, frame}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First frame after reset shows zeros.
    push_frame(16'h0000, 4'b1111, 4'b0000);
    run(R * 4);

    // Load 1234: current frame still zeros, next frame 4,3,2,1.
    push_frame(16'h0000, 4'b1111, 4'b0000);
    value = 16'h1234;
    load  = 1'b1;
    run(1);
    load  = 1'b0;
    run(R * 4 - 1);

    // Tear-free load of ABCD during the digit-2 slot.
    push_frame(16'h1234, 4'b1111, 4'b0000);
    push_frame(16'hABCD, 4'b1111, 4'b0000);
    run(2 * R + 2);
    value = 16'hABCD;
    load  = 1'b1;
    run(1);
    load  = 1'b0;
    run(R * 4 - (2 * R + 3));
    run(R * 4);

    // Leading-zero suppression: ABCD unaffected, then 0050, then 0000.
    push_frame(16'hABCD, 4'b1111, 4'b0000);
    lz_en = 1'b1;
    value = 16'h0050;
    load  = 1'b1;
    run(1);
    load  = 1'b0;
    run(R * 4 - 1);

    push_frame(16'h0050, 4'b0011, 4'b0000);
    value = 16'h0000;
    load  = 1'b1;
    run(1);
    load  = 1'b0;
    run(R * 4 - 1);

    push_frame(16'h0000, 4'b0001, 4'b0000);
    run(R * 4);

    // Decimal point on a disabled digit, then enabled.
    lz_en    = 1'b0;
    digit_en = 4'b1011;
    dp       = 4'b0100;
    value    = 16'h0000;
    load     = 1'b1;
    push_frame(16'h0000, 4'b1011, 4'b0000);
    run(1);
    load     = 1'b0;
    run(R * 4 - 1);

    push_frame(16'h0000, 4'b1011, 4'b0100);
    run(R * 4);

    digit_en = 4'b1111;
    push_frame(16'h0000, 4'b1111, 4'b0100);
    run(R * 4);

    // Asynchronous reset while digit 1 is lit.
    push_slot(0, 4'h0, 1'b1, 1'b0, R);
    push_slot(1, 4'h0, 1'b1, 1'b0, B + 1);
    run(R + B + 1);
    chk("pre_rst_an", an, 4'b1101);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", an, 4'b1111);
    chk("async_rst_nibble", nibble, 4'h0);
    chk("async_rst_dp_n", {3'b0, dp_n}, 4'd1);
    chk("async_rst_frame", {3'b0, frame}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scan restarts at digit 0 with cleared image.
    push_frame(16'h0000, 4'b1111, 4'b0000);
    run(R * 4);

    checks++;
    assert (sb_q.size() == 0) else begin
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
